mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the data-RAM/IO bus of the MEM stage between the CPU MEM stage and a secondary DMA/loader port.
//  Fixed priority to the CPU, with a starvation guard for the DMA port.
//  Locks the bus for the full read latency of the synchronous RAM.
//  Stalls the pipeline while a CPU access is pending; optionally blocks DMA access to the IO region (addr[7]=1).
// PARAMETERS
//  ADDR_W    32  address width (bit 7 = IO select, bits 6:2 = RAM word index downstream)
//  DATA_W    32  data width
//  RD_LAT    1   bus read latency in clocks, legal 1..3
//  MAX_WAIT  4   max consecutive cycles DMA may be denied before it is forced to win, legal 1..15
// PORTS
//  clock      in   1       system clock, rising edge
//  resetn     in   1       asynchronous active-low reset
//  cpu_req    in   1       CPU MEM-stage access request (load/store)
//  cpu_we     in   1       1=store, 0=load
//  cpu_addr   in   ADDR_W  CPU byte address (malu)
//  cpu_wdata  in   DATA_W  CPU store data (mb)
//  cpu_gnt    out  1       CPU access accepted this cycle
//  cpu_stall  out  1       freeze pipeline: CPU access not yet complete
//  cpu_rvalid out  1       CPU load data valid
//  cpu_rdata  out  DATA_W  CPU load data
//  dma_req    in   1       DMA access request
//  dma_we     in   1       1=write, 0=read
//  dma_addr   in   ADDR_W  DMA byte address
//  dma_wdata  in   DATA_W  DMA write data
//  dma_gnt    out  1       DMA access accepted this cycle
//  dma_rvalid out  1       DMA read data valid
//  dma_rdata  out  DATA_W  DMA read data
//  dma_err    out  1       DMA access rejected (IO_PROTECT_EN only; else tied 0)
//  bus_we     out  1       shared bus write enable (feeds RAM/IO write-enable decode)
//  bus_addr   out  ADDR_W  shared bus address
//  bus_wdata  out  DATA_W  shared bus write data
//  bus_rdata  in   DATA_W  shared bus read data (RAM/IO mux output)
// BEHAVIOUR
//  - State: owner {IDLE, CPU, DMA}; lat_cnt (2b); wait_cnt (4b, saturating at MAX_WAIT).
//  - Reset (async, resetn=0): owner=IDLE, lat_cnt=0, wait_cnt=0.
//    All outputs are 0 while in reset; any in-flight read is discarded with no rvalid.
//  - IDLE selection (combinational, same cycle):
//    - DMA wins if dma_req & (~cpu_req | wait_cnt==MAX_WAIT); else CPU wins if cpu_req; else none.
//    - Winner drives bus_we/addr/wdata this cycle and its gnt=1. With no winner, bus_we=0, bus_addr=0, bus_wdata=0.
//  - Write: completes in its grant cycle; owner stays IDLE; back-to-back writes are accepted every cycle.
//  - Read accepted in cycle T:
//    - owner<=winner, lat_cnt<=RD_LAT. bus_we=0.
//    - bus_addr is held at the accepted address for cycles T..T+RD_LAT (registered copy).
//    - lat_cnt decrements each busy cycle. In the cycle with lat_cnt==1 (=T+RD_LAT), the owner's rvalid=1 and rdata=bus_rdata (pass-through); owner<=IDLE.
//    - Earliest next grant is T+RD_LAT+1. rdata outputs are 0 when their rvalid=0.
//  - While owner!=IDLE: no grants; all requests wait.
//  - cpu_stall = cpu_req & ~(cpu_gnt & cpu_we) & ~cpu_rvalid.
//    - An uncontended CPU store never stalls. A CPU load stalls RD_LAT cycles.
//  - wait_cnt: cleared on dma_gnt or when dma_req=0; else +1 (saturating) each cycle dma_req=1 and dma_gnt=0.
//  - Simultaneous requests with wait_cnt<MAX_WAIT: CPU wins and wait_cnt increments.
//  - Requesters hold req/we/addr/wdata stable until their gnt; a req dropped before gnt is simply not served.
//  - Stall coupling: cpu_req is sourced from MEM-stage regs that cpu_stall freezes. No comb loop: stall depends on req, not vice versa.
// CONFIGURATION
//  - IO_PROTECT_EN defined: a DMA request winning IDLE with dma_addr[7]=1 gives dma_gnt=1 and dma_err=1 for one cycle.
//    - Bus is not driven by it: bus_we=0, bus_addr=0. No read is launched, no rvalid follows.
//    - wait_cnt is cleared as for a normal grant.
//  - Undefined: dma_err tied 0; DMA reaches IO addresses like RAM.
// TESTING
//  1. Idle, cpu_req=1 we=1 addr=0x10 wdata=0xDEADBEEF -> same cycle: bus_we=1, bus_addr=0x10, cpu_gnt=1, cpu_stall=0.
//  2. RD_LAT=1, CPU load addr=0x20, bus_rdata=0x1234 -> T: gnt=1, stall=1; T+1: bus_addr=0x20, cpu_rvalid=1, rdata=0x1234, stall=0.
//  3. MAX_WAIT=4, cpu and dma both hold write req continuously -> cpu_gnt cycles 0-3, dma_gnt cycle 4 with cpu_stall=1, pattern repeats.
//  4. RD_LAT=2, DMA read accepted at T, CPU store arrives T+1 -> cpu_stall=1 at T+1..T+2, dma_rvalid at T+2, cpu_gnt at T+3.
//  5. resetn pulled low at T+1 of a CPU read (RD_LAT=2) -> all outputs 0 immediately; after release owner IDLE, no cpu_rvalid ever.
//  6. dma write addr=0x84 -> with IO_PROTECT_EN: dma_gnt=dma_err=1, bus_we=0; without it: bus_we=1, bus_addr=0x84, dma_err=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares the MEM-stage data-RAM/IO bus between the CPU and a
// DMA/loader port. The CPU has fixed priority, and a saturating wait counter
// forces a DMA win after MAX_WAIT denied cycles. A read keeps the bus for
// RD_LAT cycles so that the synchronous RAM can return its data.
// Optional feature macro: IO_PROTECT_EN. When it is defined, a DMA access to
// the IO region (addr[7]=1) is granted and flagged with dma_err. It is not
// driven onto the bus.
module mem_bus_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_err,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    localparam logic [1:0] RD_LAT_C   = 2'(RD_LAT);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    owner_e            owner_q, owner_d;
    logic [1:0]        lat_cnt_q, lat_cnt_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              idle_s;
    logic              dma_win_s;
    logic              cpu_win_s;
    logic              dma_block_s;
    logic              launch_s;
    logic              done_s;
    logic              cpu_rv_s;
    logic              dma_rv_s;
    logic              win_we_s;
    logic [ADDR_W-1:0] win_addr_s;
    logic [DATA_W-1:0] win_wdata_s;

    // Arbitration: pick this cycle's winner and the bus request it presents.
    always_comb begin
        idle_s    = (owner_q == OWN_IDLE);
        dma_win_s = idle_s & dma_req & (~cpu_req | (wait_cnt_q == MAX_WAIT_C));
        cpu_win_s = idle_s & cpu_req & ~dma_win_s;
`ifdef IO_PROTECT_EN
        dma_block_s = dma_win_s & dma_addr[7];
`else
        dma_block_s = 1'b0;
`endif
        if (cpu_win_s) begin
            win_we_s    = cpu_we;
            win_addr_s  = cpu_addr;
            win_wdata_s = cpu_wdata;
        end else if (dma_win_s && !dma_block_s) begin
            win_we_s    = dma_we;
            win_addr_s  = dma_addr;
            win_wdata_s = dma_wdata;
        end else begin
            win_we_s    = 1'b0;
            win_addr_s  = {ADDR_W{1'b0}};
            win_wdata_s = {DATA_W{1'b0}};
        end
        launch_s = (cpu_win_s & ~cpu_we) | (dma_win_s & ~dma_we & ~dma_block_s);
        done_s   = ~idle_s & (lat_cnt_q == 2'd1);
        cpu_rv_s = done_s & (owner_q == OWN_CPU);
        dma_rv_s = done_s & (owner_q == OWN_DMA);
    end

    // Next-state: bus ownership, read latency countdown, held address and DMA starvation count.
    always_comb begin
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        addr_d    = addr_q;
        case (owner_q)
            OWN_IDLE: begin
                if (launch_s) begin
                    owner_d   = cpu_win_s ? OWN_CPU : OWN_DMA;
                    lat_cnt_d = RD_LAT_C;
                    addr_d    = win_addr_s;
                end else begin
                    lat_cnt_d = 2'd0;
                end
            end
            OWN_CPU, OWN_DMA: begin
                if (lat_cnt_q <= 2'd1) begin
                    owner_d   = OWN_IDLE;
                    lat_cnt_d = 2'd0;
                end else begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end
            end
            default: begin
                owner_d   = OWN_IDLE;
                lat_cnt_d = 2'd0;
            end
        endcase
        if (!dma_req || dma_win_s) begin
            wait_cnt_d = 4'd0;
        end else if (wait_cnt_q < MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State register; reset drops any in-flight read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner_q    <= OWN_IDLE;
            lat_cnt_q  <= 2'd0;
            wait_cnt_q <= 4'd0;
            addr_q     <= {ADDR_W{1'b0}};
        end else begin
            owner_q    <= owner_d;
            lat_cnt_q  <= lat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            addr_q     <= addr_d;
        end
    end

    // Outputs: grants, bus drive, read returns and stall. All outputs are forced to 0 while resetn is low.
    always_comb begin
        cpu_gnt    = 1'b0;
        cpu_stall  = 1'b0;
        cpu_rvalid = 1'b0;
        cpu_rdata  = {DATA_W{1'b0}};
        dma_gnt    = 1'b0;
        dma_rvalid = 1'b0;
        dma_rdata  = {DATA_W{1'b0}};
        dma_err    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = {ADDR_W{1'b0}};
        bus_wdata  = {DATA_W{1'b0}};
        if (resetn) begin
            cpu_gnt    = cpu_win_s;
            dma_gnt    = dma_win_s;
            dma_err    = dma_block_s;
            cpu_rvalid = cpu_rv_s;
            dma_rvalid = dma_rv_s;
            cpu_rdata  = cpu_rv_s ? bus_rdata : {DATA_W{1'b0}};
            dma_rdata  = dma_rv_s ? bus_rdata : {DATA_W{1'b0}};
            cpu_stall  = cpu_req & ~(cpu_win_s & cpu_we) & ~cpu_rv_s;
            if (idle_s) begin
                bus_we    = win_we_s;
                bus_addr  = win_addr_s;
                bus_wdata = win_wdata_s;
            end else begin
                bus_we    = 1'b0;
                bus_addr  = addr_q;
                bus_wdata = {DATA_W{1'b0}};
            end
        end else begin
            bus_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter (RD_LAT=2, MAX_WAIT=4).
// Read data that the bench expects is pushed to a queue when a read is granted.
// It is popped and compared when the matching rvalid appears.
module tb_mem_bus_arbiter;

    localparam int RD_LAT   = 2;
    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        resetn;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        dma_req, dma_we;
    logic [31:0] dma_addr, dma_wdata;
    logic        dma_gnt, dma_rvalid, dma_err;
    logic [31:0] dma_rdata;
    logic        bus_we;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int total = 0;
    int bad   = 0;
    logic [31:0] cpu_exp_q[$];
    logic [31:0] dma_exp_q[$];

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .MAX_WAIT(MAX_WAIT)) dut (
        .clock(clock), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata), .dma_err(dma_err),
        .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
    );

    always #5 clock = ~clock;

    // RAM model: read data is a fixed function of the address on the bus
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return 32'h1234_0000 ^ (a * 32'd3);
    endfunction
    assign bus_rdata = mem_f(bus_addr);

    task automatic drive_idle();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 32'h0; dma_wdata = 32'h0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h30; dma_wdata = 32'h2;
        @(negedge clock);
        total++; if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL reset_cpu_gnt got=%0h exp=0", cpu_gnt); end
        total++; if (dma_gnt !== 1'b0) begin bad++; $display("FAIL reset_dma_gnt got=%0h exp=0", dma_gnt); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL reset_bus_we got=%0h exp=0", bus_we); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL reset_bus_addr got=%0h exp=0", bus_addr); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0h exp=0", cpu_stall); end
        @(posedge clock); #1;
        drive_idle();
        resetn = 1'b1;
    endtask

    task automatic test_cpu_store();
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        @(negedge clock);
        total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL store_gnt got=%0h exp=1", cpu_gnt); end
        total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL store_stall got=%0h exp=0", cpu_stall); end
        total++; if (bus_we !== 1'b1) begin bad++; $display("FAIL store_bus_we got=%0h exp=1", bus_we); end
        total++; if (bus_addr !== 32'h10) begin bad++; $display("FAIL store_bus_addr got=%0h exp=10", bus_addr); end
        total++; if (bus_wdata !== 32'hDEADBEEF) begin bad++; $display("FAIL store_bus_wdata got=%0h exp=deadbeef", bus_wdata); end
        @(posedge clock); #1;
        drive_idle();
        @(negedge clock);
        total++; if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL store_idle_gnt got=%0h exp=0", cpu_gnt); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL store_idle_we got=%0h exp=0", bus_we); end
    endtask

    task automatic test_cpu_load(input logic [31:0] addr);
        logic        seen;
        logic [31:0] exp;
        seen = 1'b0;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
        @(negedge clock);
        total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL load_gnt got=%0h exp=1", cpu_gnt); end
        total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL load_stall_T got=%0h exp=1", cpu_stall); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL load_bus_we got=%0h exp=0", bus_we); end
        cpu_exp_q.push_back(mem_f(addr));
        for (int c = 1; c <= RD_LAT + 2; c++) begin
            @(posedge clock); #1;
            @(negedge clock);
            if (!seen) begin
                total++; if (bus_addr !== addr) begin bad++; $display("FAIL load_bus_addr_held cyc=%0d got=%0h exp=%0h", c, bus_addr, addr); end
                total++; if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL load_busy_gnt cyc=%0d got=%0h exp=0", c, cpu_gnt); end
                if (cpu_rvalid === 1'b1) begin
                    seen = 1'b1;
                    total++; if (c != RD_LAT) begin bad++; $display("FAIL load_latency got=%0d exp=%0d", c, RD_LAT); end
                    total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL load_stall_done got=%0h exp=0", cpu_stall); end
                    if (cpu_exp_q.size() == 0) begin
                        total++; bad++; $display("FAIL load_unexpected_rvalid got=1 exp=0");
                    end else begin
                        exp = cpu_exp_q.pop_front();
                        total++; if (cpu_rdata !== exp) begin bad++; $display("FAIL load_rdata got=%0h exp=%0h", cpu_rdata, exp); end
                    end
                    @(posedge clock); #1;
                    drive_idle();
                end else begin
                    total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL load_stall_wait cyc=%0d got=%0h exp=1", c, cpu_stall); end
                    total++; if (cpu_rdata !== 32'h0) begin bad++; $display("FAIL load_rdata_zero cyc=%0d got=%0h exp=0", c, cpu_rdata); end
                end
            end
        end
        if (!seen) begin
            total++; bad++; $display("FAIL load_timeout got=no_rvalid exp=rvalid");
            drive_idle();
        end
    endtask

    task automatic test_priority();
        logic exp_d;
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'h11;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h50; dma_wdata = 32'h22;
        for (int c = 0; c < 10; c++) begin
            exp_d = ((c % 5) == 4);
            @(negedge clock);
            total++; if (dma_gnt !== exp_d) begin bad++; $display("FAIL prio_dma_gnt cyc=%0d got=%0h exp=%0h", c, dma_gnt, exp_d); end
            total++; if (cpu_gnt !== !exp_d) begin bad++; $display("FAIL prio_cpu_gnt cyc=%0d got=%0h exp=%0h", c, cpu_gnt, !exp_d); end
            total++; if (cpu_stall !== exp_d) begin bad++; $display("FAIL prio_stall cyc=%0d got=%0h exp=%0h", c, cpu_stall, exp_d); end
            total++; if (bus_addr !== (exp_d ? 32'h50 : 32'h10)) begin bad++; $display("FAIL prio_bus_addr cyc=%0d got=%0h", c, bus_addr); end
            @(posedge clock); #1;
        end
        drive_idle();
    endtask

    task automatic test_wait_clear();
        logic exp_d;
        for (int c = 0; c < 9; c++) begin
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h08; cpu_wdata = 32'h33;
            dma_req = (c != 3); dma_we = 1'b1; dma_addr = 32'h60; dma_wdata = 32'h44;
            exp_d = (c == 8);
            @(negedge clock);
            total++; if (dma_gnt !== exp_d) begin bad++; $display("FAIL wclr_dma_gnt cyc=%0d got=%0h exp=%0h", c, dma_gnt, exp_d); end
            total++; if (cpu_gnt !== !exp_d) begin bad++; $display("FAIL wclr_cpu_gnt cyc=%0d got=%0h exp=%0h", c, cpu_gnt, !exp_d); end
            @(posedge clock); #1;
        end
        drive_idle();
    endtask

    task automatic test_dma_read_cpu_store();
        logic [31:0] exp;
        @(posedge clock); #1;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
        @(negedge clock);
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL dmard_gnt got=%0h exp=1", dma_gnt); end
        total++; if (bus_addr !== 32'h40) begin bad++; $display("FAIL dmard_bus_addr got=%0h exp=40", bus_addr); end
        dma_exp_q.push_back(mem_f(32'h40));
        @(posedge clock); #1;
        dma_req = 1'b0; dma_addr = 32'h0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h14; cpu_wdata = 32'h55;
        for (int c = 1; c <= RD_LAT + 1; c++) begin
            @(negedge clock);
            if (c <= RD_LAT) begin
                total++; if (cpu_stall !== 1'b1) begin bad++; $display("FAIL dmard_stall cyc=%0d got=%0h exp=1", c, cpu_stall); end
                total++; if (cpu_gnt !== 1'b0) begin bad++; $display("FAIL dmard_cpu_gnt cyc=%0d got=%0h exp=0", c, cpu_gnt); end
                total++; if (dma_rvalid !== (c == RD_LAT)) begin bad++; $display("FAIL dmard_rvalid cyc=%0d got=%0h", c, dma_rvalid); end
                if (dma_rvalid === 1'b1 && dma_exp_q.size() != 0) begin
                    exp = dma_exp_q.pop_front();
                    total++; if (dma_rdata !== exp) begin bad++; $display("FAIL dmard_rdata got=%0h exp=%0h", dma_rdata, exp); end
                end else begin
                    total++; if (dma_rdata !== 32'h0) begin bad++; $display("FAIL dmard_rdata_zero cyc=%0d got=%0h exp=0", c, dma_rdata); end
                end
            end else begin
                total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL dmard_late_gnt got=%0h exp=1", cpu_gnt); end
                total++; if (cpu_stall !== 1'b0) begin bad++; $display("FAIL dmard_late_stall got=%0h exp=0", cpu_stall); end
                total++; if (bus_we !== 1'b1 || bus_addr !== 32'h14) begin bad++; $display("FAIL dmard_late_bus got=%0h/%0h exp=1/14", bus_we, bus_addr); end
            end
            @(posedge clock); #1;
        end
        drive_idle();
        total++; if (dma_exp_q.size() != 0) begin bad++; $display("FAIL dmard_leftover got=%0d exp=0", dma_exp_q.size()); end
    endtask

    task automatic test_reset_midread();
        @(posedge clock); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h24;
        @(negedge clock);
        total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL rstrd_gnt got=%0h exp=1", cpu_gnt); end
        @(posedge clock); #1;
        resetn = 1'b0;
        #1;
        total++; if ({cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, dma_err, bus_we} !== 7'b0) begin
            bad++; $display("FAIL rstrd_ctl got=%b exp=0", {cpu_gnt, cpu_stall, cpu_rvalid, dma_gnt, dma_rvalid, dma_err, bus_we}); end
        total++; if (bus_addr !== 32'h0 || cpu_rdata !== 32'h0) begin bad++; $display("FAIL rstrd_data got=%0h/%0h exp=0/0", bus_addr, cpu_rdata); end
        @(posedge clock);
        @(posedge clock); #1;
        resetn = 1'b1;
        drive_idle();
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            total++; if (cpu_rvalid !== 1'b0) begin bad++; $display("FAIL rstrd_rvalid cyc=%0d got=%0h exp=0", c, cpu_rvalid); end
            total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL rstrd_bus_addr cyc=%0d got=%0h exp=0", c, bus_addr); end
            @(posedge clock); #1;
        end
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h18; cpu_wdata = 32'h66;
        @(negedge clock);
        total++; if (cpu_gnt !== 1'b1) begin bad++; $display("FAIL rstrd_idle_gnt got=%0h exp=1", cpu_gnt); end
        @(posedge clock); #1;
        drive_idle();
    endtask

    task automatic test_dma_io();
        @(posedge clock); #1;
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h84; dma_wdata = 32'hA5A5A5A5;
        @(negedge clock);
        total++; if (dma_gnt !== 1'b1) begin bad++; $display("FAIL io_gnt got=%0h exp=1", dma_gnt); end
`ifdef IO_PROTECT_EN
        total++; if (dma_err !== 1'b1) begin bad++; $display("FAIL io_err got=%0h exp=1", dma_err); end
        total++; if (bus_we !== 1'b0) begin bad++; $display("FAIL io_bus_we got=%0h exp=0", bus_we); end
        total++; if (bus_addr !== 32'h0) begin bad++; $display("FAIL io_bus_addr got=%0h exp=0", bus_addr); end
`else
        total++; if (dma_err !== 1'b0) begin bad++; $display("FAIL io_err got=%0h exp=0", dma_err); end
        total++; if (bus_we !== 1'b1) begin bad++; $display("FAIL io_bus_we got=%0h exp=1", bus_we); end
        total++; if (bus_addr !== 32'h84) begin bad++; $display("FAIL io_bus_addr got=%0h exp=84", bus_addr); end
`endif
        @(posedge clock); #1;
        drive_idle();
        @(negedge clock);
        total++; if (dma_err !== 1'b0 || dma_gnt !== 1'b0) begin bad++; $display("FAIL io_after got=%0h/%0h exp=0/0", dma_err, dma_gnt); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
            cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100 + 32'(i * 4); cpu_wdata = 32'hC0DE_0000 + 32'(i);
            @(negedge clock);
            total++; if (cpu_gnt !== 1'b1 || cpu_stall !== 1'b0) begin bad++; $display("FAIL b2b_gnt i=%0d got=%0h/%0h exp=1/0", i, cpu_gnt, cpu_stall); end
            total++; if (bus_addr !== 32'h100 + 32'(i * 4)) begin bad++; $display("FAIL b2b_addr i=%0d got=%0h", i, bus_addr); end
            total++; if (bus_wdata !== 32'hC0DE_0000 + 32'(i)) begin bad++; $display("FAIL b2b_wdata i=%0d got=%0h", i, bus_wdata); end
        end
        @(posedge clock); #1;
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_cpu_store();
        test_cpu_load(32'h20);
        test_cpu_load(32'h7C);
        test_priority();
        test_wait_clear();
        test_dma_read_cpu_store();
        test_reset_midread();
        test_dma_io();
        test_back_to_back();
        @(posedge clock); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
